sccb_config_sequencer: RTL and testbench

- Parametrised camera configuration engine for the OV7670 capture path.
- Walks a 16-bit command table in an external synchronous ROM of form {register, value}. Drives the camera's SCCB bus through an integrated 3-phase write engine.
- Handles table-embedded delays, camera hard-reset/power-down pins and XCLK generation.
- Raises done/error status for the capture and display logic.

---
 rtl/sccb_config_sequencer_if.sv | 21 ++
 rtl/sccb_config_sequencer.sv | 231 +++++++++++++++++++++++
 tb/tb_sccb_config_sequencer.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/sccb_config_sequencer_if.sv
// sccb_config_sequencer_if: command ROM, SCCB pins, camera control and status bundle for the sequencer
interface sccb_config_sequencer_if #(parameter int ROM_AW = 8);
  logic              start;
  logic [ROM_AW-1:0] rom_addr;
  logic [15:0]       rom_data;
  logic              sioc;
  logic              siod_out;
  logic              siod_oe;
  logic              siod_in;
  logic              cam_reset;
  logic              pwdn;
  logic              xclk;
  logic              busy;
  logic              done;
  logic              error;
  logic [ROM_AW:0]   write_count;
  modport master (input start, rom_data, siod_in,
                  output rom_addr, sioc, siod_out, siod_oe, cam_reset, pwdn, xclk, busy, done, error, write_count);
  modport slave  (output start, rom_data, siod_in,
                  input rom_addr, sioc, siod_out, siod_oe, cam_reset, pwdn, xclk, busy, done, error, write_count);
endinterface

// File: rtl/sccb_config_sequencer.sv
// sccb_config_sequencer: walks a {reg,value} ROM table and issues SCCB 3-phase writes to an OV7670.
// Optional NACK detection and per-command retry under macro SCCB_ACK_CHECK_EN.
module sccb_config_sequencer #(
  parameter int         CLK_HZ        = 50000000,
  parameter int         SCCB_HZ       = 100000,
  parameter logic [7:0] DEV_ADDR      = 8'h42,
  parameter int         ROM_AW        = 8,
  parameter int         XCLK_DIV      = 2,
  parameter int         RESET_CYCLES  = 50000,
  parameter int         SETTLE_CYCLES = 50000,
  parameter int         DELAY_UNIT    = 50000,
  parameter int         MAX_RETRY     = 3
) (
  input logic clk,
  input logic reset,
  sccb_config_sequencer_if.master bus
);
  localparam logic [31:0] QW = 32'(CLK_HZ / (4 * SCCB_HZ));
  localparam logic [31:0] RC = 32'(RESET_CYCLES - 1);
  localparam logic [31:0] SC = 32'(SETTLE_CYCLES - 1);
  localparam logic [31:0] DU = 32'(DELAY_UNIT);
  localparam logic [31:0] XH = 32'(XCLK_DIV / 2 - 1);
  typedef enum logic [3:0] {IDLE, HWRST, SETTLE, FETCH, DECODE, START, BITS, STOP, GAP, DELAY, DONE} state_t;
  state_t            r_state, w_state;
  logic [31:0]       r_cnt, w_cnt, r_xcnt, w_dly;
  logic [1:0]        r_byte, w_byte;
  logic [3:0]        r_bit, w_bit;
  logic [7:0]        r_reg, w_reg, r_val, w_val, w_sbyte;
  logic [ROM_AW-1:0] r_addr, w_addr;
  logic [ROM_AW:0]   r_wc, w_wc;
  logic              r_done, w_done, r_err, w_err, r_cam, w_cam, r_pwdn, w_pwdn;
  logic              r_sioc, w_sioc, r_oe, w_oe, r_busy, w_busy, r_xclk, w_adv;
`ifdef SCCB_ACK_CHECK_EN
  logic              r_nack, w_nack;
  logic [7:0]        r_retry, w_retry;
`else
  logic [1:0]        w_unused;
  assign w_unused = {bus.siod_in, MAX_RETRY > 0};
`endif
  assign w_dly = 32'(r_val) * DU;
  always_comb begin
    w_state = r_state;
    w_cnt   = r_cnt + 32'd1;
    w_byte  = r_byte;
    w_bit   = r_bit;
    w_reg   = r_reg;
    w_val   = r_val;
    w_addr  = r_addr;
    w_wc    = r_wc;
    w_done  = r_done;
    w_err   = r_err;
    w_cam   = r_cam;
    w_pwdn  = r_pwdn;
    w_adv   = 1'b0;
`ifdef SCCB_ACK_CHECK_EN
    w_nack  = r_nack;
    w_retry = r_retry;
`endif
    case (r_state)
      IDLE: begin
        w_cnt = '0;
        if (bus.start) begin
          w_state = HWRST;
          w_done  = 1'b0;
          w_err   = 1'b0;
          w_wc    = '0;
          w_addr  = '0;
          w_pwdn  = 1'b0;
          w_cam   = 1'b0;
        end
      end
      HWRST: if (r_cnt == RC) begin
        w_state = SETTLE;
        w_cam   = 1'b1;
        w_cnt   = '0;
      end
      SETTLE: if (r_cnt == SC) begin
        w_state = FETCH;
        w_cnt   = '0;
      end
      FETCH: begin
        w_state = DECODE;
        w_cnt   = '0;
`ifdef SCCB_ACK_CHECK_EN
        w_retry = '0;
`endif
      end
      DECODE: begin
        w_cnt = '0;
        if (bus.rom_data == 16'hFFFF) begin
          w_state = DONE;
          w_done  = 1'b1;
        end else if (bus.rom_data[15:8] == 8'hFF) begin
          w_val   = bus.rom_data[7:0];
          w_state = DELAY;
          w_adv   = bus.rom_data[7:0] == 8'h00;
        end else begin
          w_reg   = bus.rom_data[15:8];
          w_val   = bus.rom_data[7:0];
          w_state = START;
        end
      end
      START: begin
`ifdef SCCB_ACK_CHECK_EN
        w_nack = 1'b0;
`endif
        if (r_cnt == 2 * QW - 1) begin
          w_state = BITS;
          w_cnt   = '0;
          w_byte  = '0;
          w_bit   = '0;
        end
      end
      BITS: begin
`ifdef SCCB_ACK_CHECK_EN
        if (r_bit == 4'd8 && r_cnt == 2 * QW && bus.siod_in) w_nack = 1'b1;
`endif
        if (r_cnt == 4 * QW - 1) begin
          w_cnt = '0;
          w_bit = (r_bit == 4'd8) ? 4'd0 : r_bit + 4'd1;
          if (r_bit == 4'd8 && r_byte == 2'd2) w_state = STOP;
          else if (r_bit == 4'd8) w_byte = r_byte + 2'd1;
        end
      end
      STOP: if (r_cnt == 2 * QW - 1) begin
        w_cnt   = '0;
        w_state = GAP;
`ifdef SCCB_ACK_CHECK_EN
        if (!r_nack) w_wc = r_wc + 1'b1;
        else if (r_retry == 8'(MAX_RETRY)) begin
          w_err   = 1'b1;
          w_state = IDLE;
        end else w_retry = r_retry + 8'd1;
`else
        w_wc = r_wc + 1'b1;
`endif
      end
      GAP: if (r_cnt == 4 * QW - 1) begin
`ifdef SCCB_ACK_CHECK_EN
        w_cnt   = '0;
        w_state = r_nack ? START : w_state;
        w_adv   = !r_nack;
`else
        w_adv = 1'b1;
`endif
      end
      DELAY: w_adv = r_cnt == w_dly - 32'd1;
      DONE: w_state = IDLE;
      default: w_state = IDLE;
    endcase
    if (w_adv) begin
      w_cnt   = '0;
      w_state = (&r_addr) ? IDLE : FETCH;
      w_err   = (&r_addr) ? 1'b1 : w_err;
      w_addr  = (&r_addr) ? r_addr : r_addr + 1'b1;
    end
  end
  // Bus pins are evaluated on the next-state values so the registered pins match the state they belong to.
  always_comb begin
    w_sbyte = (w_byte == 2'd0) ? DEV_ADDR : (w_byte == 2'd1) ? w_reg : w_val;
    w_sioc  = (w_state == BITS) ? (w_cnt >= QW && w_cnt < 3 * QW) :
              (w_state == START) ? (w_cnt < QW) :
              (w_state == STOP) ? (w_cnt >= QW) : 1'b1;
    w_oe    = (w_state == START) || (w_state == STOP) ||
              (w_state == BITS && w_bit != 4'd8 && !w_sbyte[~w_bit[2:0]]);
    w_busy  = (w_state != IDLE) && (w_state != DONE);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_byte  <= '0;
      r_bit   <= '0;
      r_reg   <= '0;
      r_val   <= '0;
      r_addr  <= '0;
      r_wc    <= '0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      r_cam   <= 1'b1;
      r_pwdn  <= 1'b1;
      r_sioc  <= 1'b1;
      r_oe    <= 1'b0;
      r_busy  <= 1'b0;
`ifdef SCCB_ACK_CHECK_EN
      r_nack  <= 1'b0;
      r_retry <= '0;
`endif
    end else begin
      r_state <= w_state;
      r_cnt   <= w_cnt;
      r_byte  <= w_byte;
      r_bit   <= w_bit;
      r_reg   <= w_reg;
      r_val   <= w_val;
      r_addr  <= w_addr;
      r_wc    <= w_wc;
      r_done  <= w_done;
      r_err   <= w_err;
      r_cam   <= w_cam;
      r_pwdn  <= w_pwdn;
      r_sioc  <= w_sioc;
      r_oe    <= w_oe;
      r_busy  <= w_busy;
`ifdef SCCB_ACK_CHECK_EN
      r_nack  <= w_nack;
      r_retry <= w_retry;
`endif
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_xcnt <= '0;
      r_xclk <= 1'b0;
    end else if (r_xcnt == XH) begin
      r_xcnt <= '0;
      r_xclk <= ~r_xclk;
    end else r_xcnt <= r_xcnt + 32'd1;
  end
  assign bus.rom_addr    = r_addr;
  assign bus.sioc        = r_sioc;
  assign bus.siod_out    = 1'b0;
  assign bus.siod_oe     = r_oe;
  assign bus.cam_reset   = r_cam;
  assign bus.pwdn        = r_pwdn;
  assign bus.xclk        = r_xclk;
  assign bus.busy        = r_busy;
  assign bus.done        = r_done;
  assign bus.error       = r_err;
  assign bus.write_count = r_wc;
endmodule

// File: tb/tb_sccb_config_sequencer.sv
// tb_sccb_config_sequencer: directed bench with ROM model and SCCB bus decoder, Q=10, XCLK_DIV=4.
module tb_sccb_config_sequencer;
  logic clk = 1'b0, reset = 1'b1;
  int total = 0, bad = 0, cyc = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  sccb_config_sequencer_if #(.ROM_AW(2)) bus();
  sccb_config_sequencer #(.CLK_HZ(50000000), .SCCB_HZ(1250000), .DEV_ADDR(8'h42), .ROM_AW(2), .XCLK_DIV(4),
    .RESET_CYCLES(100), .SETTLE_CYCLES(100), .DELAY_UNIT(1000), .MAX_RETRY(3))
    dut (.clk(clk), .reset(reset), .bus(bus));
  logic [15:0] rom [4];
  always @(posedge clk) bus.rom_data <= rom[bus.rom_addr];
  int n_st, n_sp, nb, n_crf, t_crf, t_crr, r1, r2;
  int t_st [8], t_sp [8];
  logic [26:0] wd [8], sh;
  logic p_sioc = 1'b1, p_oe = 1'b0, p_cr = 1'b1, x_prev = 1'b0;
  int x_run = 0, x_bad = 0, x_edges = 0;
  bit x_arm = 0;
  always @(negedge clk) begin
    if (bus.cam_reset !== p_cr) begin
      if (!bus.cam_reset) begin t_crf = cyc; n_crf++; end
      else t_crr = cyc;
    end
    if (bus.siod_oe && !p_oe && bus.sioc && p_sioc) begin
      if (n_st < 8) t_st[n_st] = cyc;
      n_st++; nb = 0; sh = '0;
    end
    if (bus.sioc && !p_sioc && nb < 27) begin
      sh = {sh[25:0], !bus.siod_oe};
      if (nb == 0) r1 = cyc;
      if (nb == 1) r2 = cyc;
      nb++;
    end
    if (!bus.siod_oe && p_oe && bus.sioc) begin
      if (n_sp < 8) begin t_sp[n_sp] = cyc; wd[n_sp] = sh; end
      n_sp++;
    end
    p_sioc = bus.sioc; p_oe = bus.siod_oe; p_cr = bus.cam_reset;
    if (reset) begin
      x_arm = 0; x_run = 0;
    end else if (bus.xclk !== x_prev) begin
      if (x_arm && x_run != 2) x_bad++;
      x_arm = 1; x_run = 1; x_edges++;
    end else x_run++;
    x_prev = bus.xclk;
  end
  function automatic logic [26:0] w(input logic [7:0] r, input logic [7:0] v);
    return {8'h42, 1'b1, r, 1'b1, v, 1'b1};
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic clr();
    n_st = 0; n_sp = 0; n_crf = 0; nb = 0;
  endtask
  task automatic pulse();
    @(negedge clk); bus.start = 1'b1;
    @(negedge clk); bus.start = 1'b0;
  endtask
  task automatic wait_idle(input int budget, input string tag);
    int n = 0;
    while (bus.busy && n < budget) begin @(negedge clk); n++; end
    chk(tag, 32'(n < budget), 32'd1);
  endtask
  initial begin
    int n;
    bus.start = 1'b0; bus.siod_in = 1'b0;
    rom[0] = 16'h1280; rom[1] = 16'hFFFF; rom[2] = 16'h0000; rom[3] = 16'h0000;
    repeat (4) @(negedge clk);
    chk("rst_pins", {23'd0, bus.sioc, bus.siod_oe, bus.siod_out, bus.cam_reset, bus.pwdn, bus.busy, bus.done, bus.error, bus.xclk},
        32'b1_0011_0000);
    chk("rst_addr", 32'(bus.rom_addr), 32'd0);
    chk("rst_wc", 32'(bus.write_count), 32'd0);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    clr(); pulse();
    chk("t1_pwdn", 32'(bus.pwdn), 32'd0);
    wait_idle(3000, "t1_timeout");
    chk("t1_cam_low", 32'(t_crr - t_crf), 32'd100);
    chk("t1_first_fall", 32'(t_st[0] - t_crr), 32'd102);
    chk("t1_starts", 32'(n_st), 32'd1);
    chk("t1_word", 32'(wd[0]), 32'(w(8'h12, 8'h80)));
    chk("t1_bit_period", 32'(r2 - r1), 32'd40);
    chk("t1_status", {29'd0, bus.done, bus.error, bus.busy}, 32'b100);
    chk("t1_wc", 32'(bus.write_count), 32'd1);
    rom[0] = 16'h1204; rom[1] = 16'hFF03; rom[2] = 16'h1180; rom[3] = 16'hFFFF;
    clr(); pulse();
    n = 0;
    while (n_sp < 1 && n < 3000) begin @(negedge clk); n++; end
    chk("t2_first_stop", 32'(n < 3000), 32'd1);
    repeat (100) @(negedge clk);
    pulse();
    wait_idle(10000, "t2_timeout");
    chk("t2_gap", 32'(t_st[1] - t_sp[0]), 32'd3044);
    chk("t2_word0", 32'(wd[0]), 32'(w(8'h12, 8'h04)));
    chk("t2_word1", 32'(wd[1]), 32'(w(8'h11, 8'h80)));
    chk("t2_wc", 32'(bus.write_count), 32'd2);
    chk("t2_addr", 32'(bus.rom_addr), 32'd3);
    chk("t2_no_restart", 32'(n_crf), 32'd1);
    chk("t2_done", {30'd0, bus.done, bus.error}, 32'b10);
    rom[0] = 16'h1280; rom[1] = 16'hFFFF;
    clr(); pulse();
    n = 0;
    while (nb != 14 && n < 3000) begin @(negedge clk); n++; end
    chk("t3_reach_bit", 32'(n < 3000), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    chk("t3_abort", {27'd0, bus.sioc, bus.siod_oe, bus.busy, bus.cam_reset, bus.pwdn}, 32'b10011);
    reset = 1'b0;
    @(negedge clk);
    clr(); pulse();
    wait_idle(3000, "t3_timeout");
    chk("t3_starts", 32'(n_st), 32'd1);
    chk("t3_word", 32'(wd[0]), 32'(w(8'h12, 8'h80)));
    chk("t3_wc_done", {28'd0, bus.write_count, bus.done}, 32'b0011);
    rom[0] = 16'h1201; rom[1] = 16'h1302; rom[2] = 16'h1403; rom[3] = 16'h1504;
    clr(); pulse();
    wait_idle(8000, "t4_timeout");
    chk("t4_wc", 32'(bus.write_count), 32'd4);
    chk("t4_stops", 32'(n_sp), 32'd4);
    chk("t4_word3", 32'(wd[3]), 32'(w(8'h15, 8'h04)));
    chk("t4_status", {30'd0, bus.done, bus.error}, 32'b01);
    rom[0] = 16'h1280; rom[1] = 16'hFFFF;
    bus.siod_in = 1'b1;
    clr(); pulse();
    wait_idle(8000, "t5_timeout");
`ifdef SCCB_ACK_CHECK_EN
    chk("t5_attempts", 32'(n_st), 32'd4);
    chk("t5_status", {30'd0, bus.done, bus.error}, 32'b01);
    chk("t5_addr", 32'(bus.rom_addr), 32'd0);
`else
    chk("t5_attempts", 32'(n_st), 32'd1);
    chk("t5_status", {30'd0, bus.done, bus.error}, 32'b10);
    chk("t5_wc", 32'(bus.write_count), 32'd1);
`endif
    bus.siod_in = 1'b0;
    repeat (10) @(negedge clk);
    chk("xclk_duty", 32'(x_bad), 32'd0);
    chk("xclk_running", 32'(x_edges > 1000), 32'd1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
